// File: rtl/pc_fetch_unit_if.sv
// Handshake bundle around the IF-stage fetch unit: redirect input, imem req/gnt/rvalid port,
// and the valid/ready link toward the IF/ID register.
interface pc_fetch_unit_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  // Handshake rules: imem_req/imem_addr hold until the cycle imem_gnt is high (request accepted
  // on that edge); exactly one imem_rvalid follows each grant at least one cycle later.
  // if_valid/if_pc/if_instr hold stable until id_ready is high on a rising edge (transfer).
  logic              redirect_vld;
  logic [ADDR_W-1:0] redirect_pc;
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_gnt;
  logic              imem_rvalid;
  logic [DATA_W-1:0] imem_rdata;
  logic              if_valid;
  logic [ADDR_W-1:0] if_pc;
  logic [DATA_W-1:0] if_instr;
  logic              id_ready;

  modport master (
    input  redirect_vld, redirect_pc, imem_gnt, imem_rvalid, imem_rdata, id_ready,
    output imem_req, imem_addr, if_valid, if_pc, if_instr
  );

  modport slave (
    output redirect_vld, redirect_pc, imem_gnt, imem_rvalid, imem_rdata, id_ready,
    input  imem_req, imem_addr, if_valid, if_pc, if_instr
  );
endinterface

// File: rtl/pc_fetch_unit.sv
// IF-stage fetch unit: one imem read per PC, presented to IF/ID; handles stalls and redirects.
// Optional FETCH_COUNT_EN adds fetch_cnt, counting instructions accepted by decode.
module pc_fetch_unit #(
  parameter int                ADDR_W   = 32,
  parameter int                DATA_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  pc_fetch_unit_if.master bus,
  output logic [1:0]      dbg_state
`ifdef FETCH_COUNT_EN
  ,
  output logic [31:0]     fetch_cnt
`endif
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              drop_q, drop_d;
  logic              if_valid_q, if_valid_d;
  logic [ADDR_W-1:0] if_pc_q, if_pc_d;
  logic [DATA_W-1:0] if_instr_q, if_instr_d;
`ifdef FETCH_COUNT_EN
  logic              handshake;
  logic [31:0]       cnt_q, cnt_d;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_REQ;
      pc_q       <= RESET_PC;
      drop_q     <= 1'b0;
      if_valid_q <= 1'b0;
      if_pc_q    <= '0;
      if_instr_q <= '0;
`ifdef FETCH_COUNT_EN
      cnt_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      drop_q     <= drop_d;
      if_valid_q <= if_valid_d;
      if_pc_q    <= if_pc_d;
      if_instr_q <= if_instr_d;
`ifdef FETCH_COUNT_EN
      cnt_q      <= cnt_d;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    drop_d     = drop_q;
    if_valid_d = if_valid_q;
    if_pc_d    = if_pc_q;
    if_instr_d = if_instr_q;
`ifdef FETCH_COUNT_EN
    handshake  = 1'b0;
`endif
    unique case (state_q)
      S_REQ: begin
        if (bus.redirect_vld) pc_d = bus.redirect_pc;
        // A grant alongside a redirect means the stale address was already accepted.
        if (bus.imem_gnt) begin
          state_d = S_WAIT;
          drop_d  = bus.redirect_vld;
        end
      end
      S_WAIT: begin
        if (bus.imem_rvalid) begin
          if (bus.redirect_vld || drop_q) begin
            drop_d  = 1'b0;
            state_d = S_REQ;
          end else begin
            if_instr_d = bus.imem_rdata;
            if_pc_d    = pc_q;
            if_valid_d = 1'b1;
            pc_d       = pc_q + 1'b1;
            state_d    = S_HOLD;
          end
        end else if (bus.redirect_vld) begin
          drop_d = 1'b1;
        end
        if (bus.redirect_vld) pc_d = bus.redirect_pc;
      end
      S_HOLD: begin
        if (bus.redirect_vld) begin
          if_valid_d = 1'b0;
          pc_d       = bus.redirect_pc;
          state_d    = S_REQ;
        end else if (bus.id_ready) begin
          if_valid_d = 1'b0;
          state_d    = S_REQ;
`ifdef FETCH_COUNT_EN
          handshake  = 1'b1;
`endif
        end
      end
      default: state_d = S_REQ;
    endcase
`ifdef FETCH_COUNT_EN
    cnt_d = handshake ? cnt_q + 32'd1 : cnt_q;
`endif
  end

  always_comb begin
    bus.imem_req  = (state_q == S_REQ);
    bus.imem_addr = pc_q;
    bus.if_valid  = if_valid_q;
    bus.if_pc     = if_pc_q;
    bus.if_instr  = if_instr_q;
    dbg_state     = state_q;
`ifdef FETCH_COUNT_EN
    fetch_cnt     = cnt_q;
`endif
  end

endmodule
